// File: rtl/ahb_params_pkg.sv
// rtl/ahb_params_pkg.sv - shared AHB/APB bus types and bridge parameters
package ahb_params_pkg;

    localparam int ADDR_WIDTH       = 32;
    localparam int DATA_WIDTH       = 32;
    localparam int NO_OF_APB_SLAVES = 4;
    localparam int APB_SLOT_LSB     = 12;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [1:0] {
        HRESP_OKAY  = 2'b00,
        HRESP_ERROR = 2'b01,
        HRESP_RETRY = 2'b10,
        HRESP_SPLIT = 2'b11
    } hresp_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_ACCESS = 3'd2,
        ST_ERR1   = 3'd3,
        ST_ERR2   = 3'd4
    } apb_state_e;

    // Slot field is one value wider than the largest legal index so that
    // out-of-range slots (e.g. 5 with 4 slaves) are visible and flagged.
    function automatic int slot_width(input int n_slaves);
        return $clog2(n_slaves + 1);
    endfunction

endpackage

// File: rtl/ahb2apb_bridge_if.sv
// rtl/ahb2apb_bridge_if.sv - AHB slave side and APB master side signals of the bridge
//
// Modports:
//   slave  - the bridge view: AHB slave inputs/outputs plus the APB master outputs
//   master - the environment view: AHB master plus the APB peripheral segment
interface ahb2apb_bridge_if
    import ahb_params_pkg::*;
#(
    parameter int ADDR_W = ADDR_WIDTH,
    parameter int DATA_W = DATA_WIDTH,
    parameter int N_SLV  = NO_OF_APB_SLAVES
);
    logic              HSEL;
    logic [ADDR_W-1:0] HADDR;
    logic [1:0]        HTRANS;
    logic              HWRITE;
    logic [2:0]        HSIZE;
    logic [DATA_W-1:0] HWDATA;
    logic              HREADY;
    logic              HREADYOUT;
    logic [DATA_W-1:0] HRDATA;
    logic [1:0]        HRESP;

    logic [ADDR_W-1:0] PADDR;
    logic [N_SLV-1:0]  PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [DATA_W-1:0] PWDATA;
    logic [DATA_W-1:0] PRDATA;
    logic              PREADY;
    logic              PSLVERR;

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
        output HREADYOUT, HRDATA, HRESP,
        output PADDR, PSEL, PENABLE, PWRITE, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
        input  HREADYOUT, HRDATA, HRESP,
        input  PADDR, PSEL, PENABLE, PWRITE, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );

endinterface

// File: rtl/ahb2apb_bridge_decoder.sv
// rtl/ahb2apb_bridge_decoder.sv - combinational APB slot decoder
//
// Ports:
//   slot       in  slot-index field taken from HADDR
//   psel       out one-hot select for the addressed APB slave
//   decode_err out slot index has no APB slave behind it
module apb_slave_decoder #(
    parameter int NO_OF_APB_SLAVES = 4,
    parameter int SLOT_W           = 3
) (
    input  logic [SLOT_W-1:0]           slot,
    output logic [NO_OF_APB_SLAVES-1:0] psel,
    output logic                        decode_err
);

    always_comb begin
        psel       = '0;
        decode_err = 1'b1;
        for (int i = 0; i < NO_OF_APB_SLAVES; i++) begin
            if (slot == SLOT_W'(i)) begin
                psel[i]    = 1'b1;
                decode_err = 1'b0;
            end
        end
    end

endmodule

// File: rtl/ahb2apb_bridge.sv
// rtl/ahb2apb_bridge.sv - AHB slave to APB master bridge
//
// Ports:
//   HCLK    in  bus clock, rising edge
//   HRESETn in  asynchronous active-low reset
//   bus     slave modport: AHB slave signals in/out, APB master signals out/in
//
// Each accepted NONSEQ/SEQ transfer becomes one APB SETUP/ACCESS pair; the AHB
// data phase is stretched with HREADYOUT=0 until the APB slave completes.
// Decode errors and PSLVERR both produce the two-cycle AHB ERROR response.
module ahb2apb_bridge
    import ahb_params_pkg::*;
#(
    parameter int ADDR_WIDTH       = ahb_params_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH       = ahb_params_pkg::DATA_WIDTH,
    parameter int NO_OF_APB_SLAVES = ahb_params_pkg::NO_OF_APB_SLAVES,
    parameter int APB_SLOT_LSB     = ahb_params_pkg::APB_SLOT_LSB
) (
    input  logic            HCLK,
    input  logic            HRESETn,
    ahb2apb_bridge_if.slave bus
);

    localparam int SLOT_W = slot_width(NO_OF_APB_SLAVES);

    apb_state_e                  state_q, state_d;
    logic [NO_OF_APB_SLAVES-1:0] psel_dec;
    logic [NO_OF_APB_SLAVES-1:0] psel_q;
    logic                        dec_err;
    logic [ADDR_WIDTH-1:0]       paddr_q;
    logic                        pwrite_q;
    logic [DATA_WIDTH-1:0]       hrdata_q;
    logic                        accept;
    logic                        xfer_err;
    logic                        apb_phase;
    logic                        active_trans;

    apb_slave_decoder #(
        .NO_OF_APB_SLAVES (NO_OF_APB_SLAVES),
        .SLOT_W           (SLOT_W)
    ) u_decoder (
        .slot       (bus.HADDR[APB_SLOT_LSB +: SLOT_W]),
        .psel       (psel_dec),
        .decode_err (dec_err)
    );

    assign active_trans = (bus.HTRANS == HTRANS_NONSEQ) || (bus.HTRANS == HTRANS_SEQ);

    // New address phases are only sampled while the bridge is not holding a
    // data phase: IDLE, or the second ERROR cycle where HREADYOUT is high.
    assign accept = ((state_q == ST_IDLE) || (state_q == ST_ERR2))
                    && bus.HSEL && bus.HREADY && active_trans;

    assign xfer_err = dec_err || (bus.HSIZE > 3'b010);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q  <= ST_IDLE;
            paddr_q  <= '0;
            pwrite_q <= 1'b0;
            psel_q   <= '0;
            hrdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                paddr_q  <= bus.HADDR;
                pwrite_q <= bus.HWRITE;
                psel_q   <= psel_dec;
            end
            if ((state_q == ST_ACCESS) && bus.PREADY && !bus.PSLVERR && !pwrite_q) begin
                hrdata_q <= bus.PRDATA;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE, ST_ERR2: begin
                if (accept) begin
                    state_d = xfer_err ? ST_ERR1 : ST_SETUP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETUP:  state_d = ST_ACCESS;
            ST_ACCESS: begin
                if (bus.PREADY) begin
                    state_d = bus.PSLVERR ? ST_ERR1 : ST_IDLE;
                end
            end
            ST_ERR1:   state_d = ST_ERR2;
            default:   state_d = ST_IDLE;
        endcase
    end

    assign apb_phase = (state_q == ST_SETUP) || (state_q == ST_ACCESS);

    assign bus.PSEL      = apb_phase ? psel_q : '0;
    assign bus.PENABLE   = (state_q == ST_ACCESS);
    assign bus.PADDR     = paddr_q;
    assign bus.PWRITE    = pwrite_q;
    // HWDATA is stable for the whole stretched data phase, so it is passed
    // straight through rather than registered.
    assign bus.PWDATA    = (apb_phase && pwrite_q) ? bus.HWDATA : '0;

    assign bus.HREADYOUT = !(apb_phase || (state_q == ST_ERR1));
    assign bus.HRESP     = ((state_q == ST_ERR1) || (state_q == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
    assign bus.HRDATA    = hrdata_q;

endmodule

// File: tb/tb_ahb2apb_bridge.sv
// tb/tb_ahb2apb_bridge.sv - directed self-checking bench for ahb2apb_bridge
module tb_ahb2apb_bridge;
    import ahb_params_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    ahb2apb_bridge_if bus ();

    assign bus.HREADY = bus.HREADYOUT;

    ahb2apb_bridge dut (
        .HCLK    (clk),
        .HRESETn (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic addr_phase(input logic [31:0] a, input logic w, input logic [2:0] sz,
                              input logic [1:0] tr);
        bus.HSEL   = 1'b1;
        bus.HADDR  = a;
        bus.HWRITE = w;
        bus.HSIZE  = sz;
        bus.HTRANS = tr;
    endtask

    task automatic no_addr();
        bus.HSEL   = 1'b0;
        bus.HTRANS = HTRANS_IDLE;
        bus.HWRITE = 1'b0;
    endtask

    // Called at the sample point of the cycle that precedes ERR1.
    task automatic expect_error(input string tag);
        tick(); no_addr(); smp();
        check({tag, "_err1_resp"},  32'(bus.HRESP), 32'h1);
        check({tag, "_err1_ready"}, 32'(bus.HREADYOUT), 32'h0);
        check({tag, "_err1_psel"},  32'(bus.PSEL), 32'h0);
        tick(); smp();
        check({tag, "_err2_resp"},  32'(bus.HRESP), 32'h1);
        check({tag, "_err2_ready"}, 32'(bus.HREADYOUT), 32'h1);
        tick(); smp();
        check({tag, "_after_resp"},  32'(bus.HRESP), 32'h0);
        check({tag, "_after_ready"}, 32'(bus.HREADYOUT), 32'h1);
    endtask

    initial begin
        no_addr();
        bus.HADDR   = '0;
        bus.HSIZE   = 3'b010;
        bus.HWDATA  = '0;
        bus.PRDATA  = '0;
        bus.PREADY  = 1'b1;
        bus.PSLVERR = 1'b0;

        // Reset values
        smp();
        check("rst_hreadyout", 32'(bus.HREADYOUT), 32'h1);
        check("rst_hresp",     32'(bus.HRESP), 32'h0);
        check("rst_hrdata",    bus.HRDATA, 32'h0);
        check("rst_psel",      32'(bus.PSEL), 32'h0);
        check("rst_penable",   32'(bus.PENABLE), 32'h0);
        check("rst_pwrite",    32'(bus.PWRITE), 32'h0);
        check("rst_paddr",     bus.PADDR, 32'h0);
        check("rst_pwdata",    bus.PWDATA, 32'h0);
        tick(); tick();
        rst_n = 1'b1;

        // Zero-wait write to slot 1
        tick(); addr_phase(32'h0000_1004, 1'b1, 3'b010, HTRANS_NONSEQ); smp();
        check("w_t0_ready", 32'(bus.HREADYOUT), 32'h1);
        tick(); no_addr(); bus.HWDATA = 32'hDEAD_BEEF; smp();
        check("w_setup_psel",   32'(bus.PSEL), 32'h2);
        check("w_setup_pen",    32'(bus.PENABLE), 32'h0);
        check("w_setup_pwdata", bus.PWDATA, 32'hDEAD_BEEF);
        check("w_setup_paddr",  bus.PADDR, 32'h0000_1004);
        check("w_setup_pwrite", 32'(bus.PWRITE), 32'h1);
        check("w_setup_ready",  32'(bus.HREADYOUT), 32'h0);
        tick(); smp();
        check("w_access_psel",  32'(bus.PSEL), 32'h2);
        check("w_access_pen",   32'(bus.PENABLE), 32'h1);
        check("w_access_ready", 32'(bus.HREADYOUT), 32'h0);
        tick(); smp();
        check("w_done_ready", 32'(bus.HREADYOUT), 32'h1);
        check("w_done_resp",  32'(bus.HRESP), 32'h0);
        check("w_done_psel",  32'(bus.PSEL), 32'h0);

        // Read from slot 2 with three PREADY-low cycles
        tick(); addr_phase(32'h0000_2000, 1'b0, 3'b010, HTRANS_NONSEQ); bus.HWDATA = '0;
        bus.PREADY = 1'b0; bus.PRDATA = 32'h0BAD_0BAD;
        for (int i = 0; i < 5; i++) begin
            tick();
            no_addr();
            bus.PREADY = (i == 4);
            bus.PRDATA = (i == 4) ? 32'h1234_5678 : 32'h0BAD_0BAD;
            smp();
            check($sformatf("r_ws%0d_paddr", i), bus.PADDR, 32'h0000_2000);
            check($sformatf("r_ws%0d_ready", i), 32'(bus.HREADYOUT), 32'h0);
            check($sformatf("r_ws%0d_psel", i),  32'(bus.PSEL), 32'h4);
            check($sformatf("r_ws%0d_pen", i),   32'(bus.PENABLE), (i == 0) ? 32'h0 : 32'h1);
            check($sformatf("r_ws%0d_pwdata", i), bus.PWDATA, 32'h0);
        end
        tick(); bus.PRDATA = '0; smp();
        check("r_done_ready",  32'(bus.HREADYOUT), 32'h1);
        check("r_done_hrdata", bus.HRDATA, 32'h1234_5678);
        check("r_done_resp",   32'(bus.HRESP), 32'h0);

        // Write to slot 3 completing with PSLVERR
        tick(); addr_phase(32'h0000_3000, 1'b1, 3'b010, HTRANS_NONSEQ); smp();
        tick(); no_addr(); bus.HWDATA = 32'h0000_00AA; smp();
        check("se_setup_psel", 32'(bus.PSEL), 32'h8);
        tick(); bus.PSLVERR = 1'b1; bus.PRDATA = 32'hFFFF_FFFF; smp();
        check("se_access_pen", 32'(bus.PENABLE), 32'h1);
        expect_error("slverr");
        bus.PSLVERR = 1'b0;
        check("se_hrdata_kept", bus.HRDATA, 32'h1234_5678);

        // Decode error: slot 5
        tick(); addr_phase(32'h0000_5000, 1'b0, 3'b010, HTRANS_NONSEQ); smp();
        check("dec_t0_ready", 32'(bus.HREADYOUT), 32'h1);
        expect_error("dec");

        // Decode error: 64-bit size
        tick(); addr_phase(32'h0000_1000, 1'b0, 3'b011, HTRANS_NONSEQ); smp();
        expect_error("hsize");

        // Back-to-back read then write, second address in the completion cycle
        tick(); addr_phase(32'h0000_1008, 1'b0, 3'b010, HTRANS_NONSEQ);
        bus.PRDATA = 32'hCAFE_F00D; smp();
        tick(); no_addr(); smp();
        check("b2b_r_setup_psel", 32'(bus.PSEL), 32'h2);
        tick(); smp();
        check("b2b_r_access_pen", 32'(bus.PENABLE), 32'h1);
        tick(); addr_phase(32'h0000_2010, 1'b1, 3'b010, HTRANS_NONSEQ); smp();
        check("b2b_r_done_ready",  32'(bus.HREADYOUT), 32'h1);
        check("b2b_r_done_hrdata", bus.HRDATA, 32'hCAFE_F00D);
        tick(); no_addr(); bus.HWDATA = 32'h0000_55AA; smp();
        check("b2b_w_setup_psel",   32'(bus.PSEL), 32'h4);
        check("b2b_w_setup_pen",    32'(bus.PENABLE), 32'h0);
        check("b2b_w_setup_paddr",  bus.PADDR, 32'h0000_2010);
        check("b2b_w_setup_pwdata", bus.PWDATA, 32'h0000_55AA);
        tick(); smp();
        tick(); smp();
        check("b2b_w_done_ready", 32'(bus.HREADYOUT), 32'h1);

        // BUSY then IDLE transfers: OKAY, no APB activity
        tick(); addr_phase(32'h0000_1000, 1'b0, 3'b010, HTRANS_BUSY); smp();
        tick(); addr_phase(32'h0000_1000, 1'b0, 3'b010, HTRANS_IDLE); smp();
        check("busy_psel",  32'(bus.PSEL), 32'h0);
        check("busy_ready", 32'(bus.HREADYOUT), 32'h1);
        check("busy_resp",  32'(bus.HRESP), 32'h0);
        tick(); no_addr(); smp();
        check("idle_psel",  32'(bus.PSEL), 32'h0);
        check("idle_ready", 32'(bus.HREADYOUT), 32'h1);

        // Asynchronous reset during ACCESS
        tick(); addr_phase(32'h0000_1000, 1'b1, 3'b010, HTRANS_NONSEQ); smp();
        tick(); no_addr(); bus.PREADY = 1'b0; smp();
        tick(); smp();
        check("ar_access_pen", 32'(bus.PENABLE), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("ar_psel",  32'(bus.PSEL), 32'h0);
        check("ar_pen",   32'(bus.PENABLE), 32'h0);
        check("ar_ready", 32'(bus.HREADYOUT), 32'h1);
        tick(); rst_n = 1'b1; bus.PREADY = 1'b1; bus.HWDATA = '0;

        // Normal read after reset release
        tick(); addr_phase(32'h0000_3004, 1'b0, 3'b010, HTRANS_NONSEQ);
        bus.PRDATA = 32'hA5A5_0001; smp();
        tick(); no_addr(); smp();
        check("pr_setup_psel", 32'(bus.PSEL), 32'h8);
        tick(); smp();
        tick(); smp();
        check("pr_done_ready",  32'(bus.HREADYOUT), 32'h1);
        check("pr_done_hrdata", bus.HRDATA, 32'hA5A5_0001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
